ps2_key_fifo: RTL
=================

PS2_KEY_FIFO -- requirements
Module: ps2_key_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 20000: clk cycles without a ps2_clk falling edge before a partial frame is aborted.
REQ-003 SHALL have port clk  input  1: single clock; all state on posedge clk.
REQ-004 SHALL have port rstn  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk  input  1: raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1: raw PS/2 data, asynchronous to clk.
REQ-007 SHALL have port pop  input  1: one-cycle strobe from the CPU IO-read path that consumes the head entry.
REQ-008 SHALL have port clr_ovf  input  1: clears the overflow flag.
REQ-009 SHALL have port key_valid  output  1: FIFO not empty.
REQ-010 SHALL have port key_code  output  5: head entry, first-word-fall-through; 0 when empty.
REQ-011 SHALL have port count  output  5: number of entries held, 0..DEPTH.
REQ-012 SHALL have port overflow  output  1: sticky; set when a key was dropped.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers and detect ps2_clk falling edges on the synchronized signal; sampled data is the synchronized ps2_data in the edge cycle.
REQ-014 SHALL run frame FSM IDLE->DATA->PARITY->STOP->IDLE, advancing only on falling edges.
REQ-015 IDLE: edge with data=0 -> DATA, bit counter=0; edge with data=1 stays in IDLE.
REQ-016 DATA: shift in 8 bits LSB first; after the 8th bit -> PARITY.
REQ-017 PARITY: record parity_ok = (XOR of the 8 data bits and the parity bit) == 1 (odd parity); -> STOP.
REQ-018 STOP: frame is good iff parity_ok and stop bit=1; -> IDLE unconditionally; bad frames are discarded silently.
REQ-019 Timeout counter SHALL clear on every falling edge and in IDLE; when it reaches TIMEOUT_CYC outside IDLE the FSM returns to IDLE and discards the partial byte.
REQ-020 Good byte 0xF0 SHALL set break flag and push nothing; the next good byte clears the flag and is discarded (key release).
REQ-021 Good byte 0xE0 SHALL be ignored without touching the break flag.
REQ-022 Map make codes: 0x45,16,1E,26,25,2E,36,3D,3E,46 -> 0..9; 0x1C,32,21,23,24,2B -> 10..15; 0x5A (Enter) -> 16; 0x66 (Backspace) -> 17; all other bytes are discarded.
REQ-023 A mapped key SHALL be pushed in the cycle after the stop-bit edge; latency from the stop-bit edge to key_valid=1 (empty FIFO) is 2 clk.
REQ-024 pop when empty SHALL be ignored; count never underflows.
REQ-025 Push when full without pop SHALL drop the new key and set overflow; FIFO contents unchanged.
REQ-026 Simultaneous push and pop when full SHALL accept both; count stays DEPTH; overflow unchanged.
REQ-027 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH.
REQ-029 clr_ovf SHALL clear overflow next cycle; if a drop occurs in the same cycle, set wins.

Reset
REQ-030 On rstn=0, asynchronously: FSM=IDLE, bit counter, timeout counter, shift register=0, break flag=0, pointers=0, count=0, overflow=0, key_valid=0, key_code=0, synchronizer flops=1 (idle-high line).
REQ-031 Reset mid-frame SHALL discard the partial byte; the first frame recognised after release needs a fresh start bit.

Structure
REQ-032 Shared package cpu_io_pkg SHALL hold the FSM state enum, the scan-code constants (0xF0, 0xE0, digit/hex make codes) and key-code constants KEY_ENTER=16 and KEY_BKSP=17.
REQ-033 The FIFO SHALL be a sub-module key_fifo (DEPTH, push/pop/din/dout/count/full/empty); frame decode and mapping stay in ps2_key_fifo.

Verification
REQ-034 Frame 0x16 with good parity and stop bit -> key_valid=1, key_code=1 two clk after the stop edge; pop -> key_valid=0, count=0.
REQ-035 Sequence 0x1C, F0, 1C, 5A -> exactly two entries, 10 then 16; the release 0x1C is not pushed.
REQ-036 Frame 0x26 with parity bit inverted -> no push; following good 0x3E -> key_code=8.
REQ-037 Push 9 keys (DEPTH=8) with no pop -> count=8, overflow=1, head = 1st key; pop+push in same cycle when full -> count=8, overflow unchanged.
REQ-038 Start bit plus 4 data bits, then ps2_clk held high TIMEOUT_CYC cycles -> FSM IDLE, no push; next full frame 0x45 -> key_code=0.
REQ-039 rstn pulsed low during the DATA state with count=3 -> count=0, overflow=0, key_valid=0; next full frame 0x5A -> key_code=16.

Source files
------------

// File: rtl/cpu_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_io_pkg
// Description : Shared types and constants for the PS/2 keypad front end:
//               frame FSM states, scan-code values, key-code values and the
//               make-code to key-code lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_io_pkg;

  // Width of a mapped key code (0..17 fits in 5 bits).
  localparam int unsigned KEY_W = 5;

  // PS/2 frame receiver states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Prefix bytes.
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXTEND = 8'hE0;

  // Make codes for the digit keys 0..9.
  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;

  // Make codes for the hex letter keys A..F.
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;

  // Control keys.
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  localparam logic [KEY_W-1:0] KEY_ENTER = 5'd16;
  localparam logic [KEY_W-1:0] KEY_BKSP  = 5'd17;

  // Result of a scan-code lookup: hit=0 means the byte is not a mapped key.
  typedef struct packed {
    logic             hit;
    logic [KEY_W-1:0] code;
  } key_map_t;

  // Translate a make code into the CPU-facing key code.
  function automatic key_map_t map_scan(input logic [7:0] sc);
    key_map_t m;
    m.hit  = 1'b1;
    m.code = '0;
    case (sc)
      SC_0:     m.code = 5'd0;
      SC_1:     m.code = 5'd1;
      SC_2:     m.code = 5'd2;
      SC_3:     m.code = 5'd3;
      SC_4:     m.code = 5'd4;
      SC_5:     m.code = 5'd5;
      SC_6:     m.code = 5'd6;
      SC_7:     m.code = 5'd7;
      SC_8:     m.code = 5'd8;
      SC_9:     m.code = 5'd9;
      SC_A:     m.code = 5'd10;
      SC_B:     m.code = 5'd11;
      SC_C:     m.code = 5'd12;
      SC_D:     m.code = 5'd13;
      SC_E:     m.code = 5'd14;
      SC_F:     m.code = 5'd15;
      SC_ENTER: m.code = KEY_ENTER;
      SC_BKSP:  m.code = KEY_BKSP;
      default: begin
        m.hit  = 1'b0;
        m.code = '0;
      end
    endcase
    return m;
  endfunction

endpackage : cpu_io_pkg
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// ============================================================================
// Module      : key_fifo
// Description : Small first-word-fall-through FIFO for decoded key codes.
//               A push while full is accepted only if a pop happens in the
//               same cycle; otherwise the new entry is dropped (the caller
//               flags the drop). Output reads 0 when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module key_fifo
  import cpu_io_pkg::*;
#(
  parameter int unsigned DEPTH = 8   // power of two, 2..16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [KEY_W-1:0] din,
  output logic [KEY_W-1:0] dout,
  output logic [4:0]       count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [4:0]       count_q;

  logic w_do_push;
  logic w_do_pop;

  assign full  = (count_q == 5'(DEPTH));
  assign empty = (count_q == 5'd0);

  // Pops on an empty FIFO are ignored; a full FIFO takes a push only when
  // the head is leaving in the same cycle.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : key_fifo
`default_nettype wire

// File: rtl/ps2_key_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_fifo
// Description : PS/2 keyboard receiver for a hex keypad. Synchronises the raw
//               PS/2 lines, decodes 11-bit frames, filters break/extended
//               prefixes, maps make codes to key codes 0..17 and queues them
//               in a FIFO read by the CPU. Sticky overflow on dropped keys.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_fifo
  import cpu_io_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             pop,
  input  logic             clr_ovf,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  output logic [4:0]       count,
  output logic             overflow
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  // Synchroniser and edge-detect flops (idle-high line).
  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_prev_q;

  // Frame receiver state.
  ps2_state_e       state_q,   state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q,   shift_d;
  logic             par_ok_q,  par_ok_d;
  logic [TMO_W-1:0] tmo_q,     tmo_d;
  logic             brk_q,     brk_d;
  logic             push_q,    push_d;
  logic [KEY_W-1:0] code_q,    code_d;
  logic             ovf_q;

  logic             w_fall;
  logic             w_data;
  key_map_t         w_map;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;

  assign w_fall = clk_prev_q & ~clk_sync_q[1];
  assign w_data = dat_sync_q[1];
  assign w_map  = map_scan(shift_q);

  // Two-flop synchronisers plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  // Frame receiver registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_ok_q  <= 1'b0;
      tmo_q     <= '0;
      brk_q     <= 1'b0;
      push_q    <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_ok_q  <= par_ok_d;
      tmo_q     <= tmo_d;
      brk_q     <= brk_d;
      push_q    <= push_d;
      code_q    <= code_d;
    end
  end

  // Frame decode, prefix filtering, key mapping and stall timeout.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    brk_d     = brk_q;
    push_d    = 1'b0;
    code_d    = code_q;

    if ((state_q == ST_IDLE) || w_fall) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (w_fall) begin
      case (state_q)
        ST_IDLE: begin
          // A high bit while idle is line noise, not a start bit.
          if (!w_data) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {w_data, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_ok_d = ^{shift_q, w_data};
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (par_ok_q && w_data) begin
            if (shift_q == SC_BREAK) begin
              brk_d = 1'b1;
            end else if (shift_q == SC_EXTEND) begin
              // Extended prefix carries no key and leaves the break state alone.
              brk_d = brk_q;
            end else if (brk_q) begin
              // Byte following a break prefix is a key release: drop it.
              brk_d = 1'b0;
            end else if (w_map.hit) begin
              push_d = 1'b1;
              code_d = w_map.code;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYC))) begin
      // Keyboard stalled mid-frame: abandon the partial byte.
      state_d = ST_IDLE;
      tmo_d   = '0;
    end
  end

  // A full FIFO only refuses the push when no pop frees a slot this cycle.
  assign w_drop = push_q & w_full & ~pop;

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else if (w_drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  key_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_q),
    .pop   (pop),
    .din   (code_q),
    .dout  (key_code),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign key_valid = ~w_empty;
  assign overflow  = ovf_q;

endmodule : ps2_key_fifo
`default_nettype wire
